// File: rtl/full_fn_stream_seq.sv
// full_fn_stream_seq
//   Streaming sequencer between the mSGDMA read-master Avalon-ST source and a
//   fixed-latency compute core. It accepts elem_count elements from the DMA,
//   issues each one to the core a cycle after acceptance, collects the core
//   results in a show-ahead FIFO, and streams them toward the write master.
//
//   Ports
//     clk, aclr             clock, synchronous active-high reset
//     ctrl_reset/start      CSR soft-reset and start pulses
//     elem_count            element count, sampled on an accepted start
//     snk_*                 Avalon-ST sink from the DMA read master
//     core_in_* / core_out_* element issue to core / result return from core
//     src_*                 Avalon-ST source toward the DMA write master
//     busy, done, progress  status for the CSR block
//
//   Optional: define FULL_FN_STREAM_EOP_EN to add src_startofpacket and
//   src_endofpacket on the source.
module full_fn_stream_seq #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int PIPE_LAT   = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              ctrl_reset,
  input  logic              ctrl_start,
  input  logic [CNT_W-1:0]  elem_count,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [DATA_W-1:0] snk_data,
  output logic              core_in_valid,
  output logic [DATA_W-1:0] core_in_data,
  input  logic              core_out_valid,
  input  logic [DATA_W-1:0] core_out_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_data,
`ifdef FULL_FN_STREAM_EOP_EN
  output logic              src_startofpacket,
  output logic              src_endofpacket,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  progress
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IFW = AW + 1;
  localparam int FW  = $clog2(PIPE_LAT + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_FLUSH} state_e;
  state_e state_q, state_d;

  logic [CNT_W-1:0]  target_q, accepted_q, progress_q;
  logic [IFW-1:0]    inflight_q;
  logic [AW:0]       wptr_q, rptr_q, level;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [FW-1:0]     flush_cnt_q;
  logic              cin_vld_q;
  logic [DATA_W-1:0] cin_data_q;

  logic        start_ok, xfer, push, pop, ret, credit_ok;
  logic [IFW:0] used;

  assign level = wptr_q - rptr_q;
  // inflight is charged at acceptance, so it already covers the element
  // sitting in the issue register; together with the FIFO level it bounds
  // every result that can still land in the FIFO.
  assign used      = {1'b0, inflight_q} + {1'b0, level};
  assign credit_ok = used < (IFW+1)'(FIFO_DEPTH);

  assign start_ok  = ctrl_start && !ctrl_reset &&
                     (state_q == S_IDLE || state_q == S_DONE);
  assign snk_ready = (state_q == S_RUN) && !ctrl_reset &&
                     (accepted_q < target_q) && credit_ok;
  assign xfer      = snk_valid && snk_ready;
  assign src_valid = (level != '0) && !ctrl_reset;
  assign src_data  = mem_q[rptr_q[AW-1:0]];
  assign pop       = src_valid && src_ready;
  // Results returning during a flush belong to the aborted run; drop them.
  assign push      = core_out_valid && !ctrl_reset && (state_q != S_FLUSH) &&
                     !level[AW];
  assign ret       = core_out_valid && (inflight_q != '0) && (state_q != S_FLUSH);

  assign core_in_valid = cin_vld_q;
  assign core_in_data  = cin_data_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN) ||
                         (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);
  assign progress      = progress_q;

`ifdef FULL_FN_STREAM_EOP_EN
  assign src_startofpacket = src_valid && (progress_q == '0);
  assign src_endofpacket   = src_valid && ((progress_q + CNT_W'(1)) == target_q);
`endif

  always_comb begin
    state_d = state_q;
    if (ctrl_reset) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE, S_DONE:
          if (ctrl_start) state_d = (elem_count == '0) ? S_DONE : S_RUN;
        S_RUN:
          if (xfer && (accepted_q + CNT_W'(1)) == target_q) state_d = S_DRAIN;
        S_DRAIN:
          if (inflight_q == '0 && level == '0 && !cin_vld_q) state_d = S_DONE;
        S_FLUSH:
          if (flush_cnt_q == FW'(PIPE_LAT)) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (aclr || ctrl_reset) begin
      target_q    <= '0;
      accepted_q  <= '0;
      progress_q  <= '0;
      inflight_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cin_vld_q   <= 1'b0;
      cin_data_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      cin_vld_q  <= xfer;
      cin_data_q <= xfer ? snk_data : '0;
      if (start_ok) begin
        target_q   <= elem_count;
        accepted_q <= '0;
        progress_q <= '0;
      end else begin
        if (xfer) accepted_q <= accepted_q + CNT_W'(1);
        if (pop && progress_q != '1) progress_q <= progress_q + CNT_W'(1);
      end
      case ({xfer, ret})
        2'b10:   inflight_q <= inflight_q + IFW'(1);
        2'b01:   inflight_q <= inflight_q - IFW'(1);
        default: ;
      endcase
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      if (state_q == S_FLUSH) flush_cnt_q <= flush_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= core_out_data;
  end

endmodule

// File: tb/tb_full_fn_stream_seq.sv
module tb_full_fn_stream_seq;
  localparam int PIPE_LAT = 16;
  localparam int DEPTH    = 32;

  logic        clk = 0;
  logic        aclr = 1, ctrl_reset = 0, ctrl_start = 0;
  logic [31:0] elem_count = 0;
  logic        snk_valid = 0, snk_ready;
  logic [31:0] snk_data = 0;
  logic        core_in_valid, core_out_valid;
  logic [31:0] core_in_data, core_out_data;
  logic        src_valid, src_ready = 1;
  logic [31:0] src_data;
  logic        busy, done;
  logic [31:0] progress;
`ifdef FULL_FN_STREAM_EOP_EN
  logic        sop, eop;
`endif

  full_fn_stream_seq #(.DATA_W(32), .CNT_W(32), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .aclr(aclr), .ctrl_reset(ctrl_reset), .ctrl_start(ctrl_start),
    .elem_count(elem_count), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .snk_data(snk_data), .core_in_valid(core_in_valid), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
`ifdef FULL_FN_STREAM_EOP_EN
    .src_startofpacket(sop), .src_endofpacket(eop),
`endif
    .busy(busy), .done(done), .progress(progress));

  always #5 clk = ~clk;

  function automatic logic [31:0] fn(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h3F80_0000;
  endfunction

  // Fixed-latency core model
  logic [PIPE_LAT-1:0] dv;
  logic [31:0]         dd [PIPE_LAT];
  always @(posedge clk) begin
    if (aclr) dv <= '0;
    else      dv <= {dv[PIPE_LAT-2:0], core_in_valid};
    dd[0] <= fn(core_in_data);
    for (int i = 1; i < PIPE_LAT; i++) dd[i] <= dd[i-1];
  end
  assign core_out_valid = dv[PIPE_LAT-1];
  assign core_out_data  = dd[PIPE_LAT-1];

  int checks = 0, errors = 0;
  logic [31:0] exp_q [$];
  int acc_cnt = 0, pop_idx = 0, exp_target = 0;
  bit mon_en = 0;
  logic prev_acc = 0;
  logic [31:0] prev_dat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard producer (accepted beats) and monitor (issue timing, source)
  always @(negedge clk) if (mon_en) begin
    chk("core_in_valid", {31'b0, core_in_valid}, {31'b0, prev_acc});
    chk("core_in_data", core_in_data, prev_acc ? prev_dat : 32'h0);
    prev_acc = snk_valid && snk_ready;
    prev_dat = snk_data;
    if (prev_acc) begin
      exp_q.push_back(fn(snk_data));
      acc_cnt++;
    end
    if (src_valid && src_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL src_unexpected got %h expected none", src_data);
      end else chk("src_data", src_data, exp_q.pop_front());
`ifdef FULL_FN_STREAM_EOP_EN
      chk("sop", {31'b0, sop}, {31'b0, pop_idx == 0});
      chk("eop", {31'b0, eop}, {31'b0, pop_idx + 1 == exp_target});
`endif
      pop_idx++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start(input int cnt);
    elem_count = cnt; ctrl_start = 1; exp_target = cnt; pop_idx = 0; acc_cnt = 0;
    tick();
    ctrl_start = 0;
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      snk_valid = 1; snk_data = base + i;
      @(negedge clk);
      while (!snk_ready && w < 3000) begin @(negedge clk); w++; end
      if (!snk_ready) begin
        checks++; errors++;
        $display("FAIL feed_timeout got ready=0 expected ready=1");
        break;
      end
      @(posedge clk); #1;
    end
    snk_valid = 0; snk_data = 0;
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!done && w < 3000) begin @(negedge clk); w++; end
    chk(name, {31'b0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic status(input string tag, input int prog);
    @(negedge clk);
    chk({tag, "_progress"}, progress, prog);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    aclr = 0;
    mon_en = 1;
    @(negedge clk);
    chk("rst_snk_ready", {31'b0, snk_ready}, 0);
    chk("rst_src_valid", {31'b0, src_valid}, 0);
    chk("rst_core_in", {31'b0, core_in_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_progress", progress, 0);
    tick();

    // four back-to-back elements
    start(4);
    feed(4, 32'h0000_0100);
    wait_done("t1_done");
    status("t1", 4);

    // zero-length run
    start(0);
    chk("t2_done_next", {31'b0, done}, 1);
    snk_valid = 1; snk_data = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t2_snk_ready", {31'b0, snk_ready}, 0);
      @(posedge clk); #1;
    end
    snk_valid = 0;
    status("t2", 0);

    // backpressure: credit limit at FIFO depth
    src_ready = 0;
    start(40);
    fork feed(40, 32'h0002_0000); join_none
    tick(80);
    @(negedge clk);
    chk("t3_acc_limit", acc_cnt, DEPTH);
    chk("t3_snk_ready", {31'b0, snk_ready}, 0);
    chk("t3_src_valid", {31'b0, src_valid}, 1);
    @(posedge clk); #1;
    src_ready = 1;
    wait_done("t3_done");
    chk("t3_acc_total", acc_cnt, 40);
    status("t3", 40);

    // over-supply: beats beyond target stay pending
    start(3);
    feed(3, 32'h0003_0000);
    snk_valid = 1; snk_data = 32'h0003_0003;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t4_snk_ready", {31'b0, snk_ready}, 0);
      @(posedge clk); #1;
    end
    wait_done("t4_done");
    snk_valid = 0;
    chk("t4_acc", acc_cnt, 3);
    status("t4", 3);

    // soft reset mid-run, then flush
    start(10);
    feed(5, 32'h0005_0000);
    ctrl_reset = 1;
    exp_q.delete();
    tick();
    ctrl_reset = 0;
    for (int i = 0; i < PIPE_LAT + 1; i++) begin
      @(negedge clk);
      chk("t5_flush_busy", {31'b0, busy}, 1);
      chk("t5_flush_src", {31'b0, src_valid}, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t5_idle_busy", {31'b0, busy}, 0);
    chk("t5_idle_done", {31'b0, done}, 0);
    chk("t5_idle_progress", progress, 0);
    @(posedge clk); #1;
    start(2);
    feed(2, 32'h0006_0000);
    wait_done("t5b_done");
    status("t5b", 2);

    // start while busy is ignored
    start(6);
    fork feed(6, 32'h0007_0000); join_none
    tick(3);
    elem_count = 99; ctrl_start = 1;
    tick();
    ctrl_start = 0;
    @(negedge clk);
    chk("t6_busy", {31'b0, busy}, 1);
    @(posedge clk); #1;
    wait_done("t6_done");
    chk("t6_acc", acc_cnt, 6);
    status("t6", 6);

    // single-element run (SOP and EOP on one beat when enabled)
    start(1);
    feed(1, 32'h0008_0000);
    wait_done("t7_done");
    status("t7", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_fn_stream_seq.md
Name: full_fn_stream_seq

Overview:
- Streaming sequencer between the mSGDMA read-master Avalon-ST source and the fixed-latency cosine/full-function compute pipeline.
- Consumes control fields decoded from the accelerator CSR block: soft reset, start, and expected element count.
- Pulls 32-bit elements from the DMA and issues them to the core.
- Buffers core results in an output FIFO, drives them onto an Avalon-ST source toward the mSGDMA write master, and reports busy/done/progress back for the CSR status and progress registers.

Parameters:
- DATA_W, 32, element width (IEEE-754 single).
- CNT_W, 32, width of element count and progress.
- PIPE_LAT, 16, fixed core latency in cycles, input valid to output valid; must be ≥1.
- FIFO_DEPTH, 32, output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- aclr  in  1  reset: synchronous, active-high.
- ctrl_reset  in  1  soft reset pulse (CSR control bit 0).
- ctrl_start  in  1  start pulse (CSR control bit 2).
- elem_count  in  CNT_W  number of elements to process; sampled on accepted start.
- snk_valid  in  1  DMA stream valid.
- snk_ready  out  1  DMA stream ready.
- snk_data  in  DATA_W  DMA stream data.
- core_in_valid  out  1  element issue strobe to core.
- core_in_data  out  DATA_W  element to core.
- core_out_valid  in  1  core result strobe; arrives exactly PIPE_LAT cycles after core_in_valid.
- core_out_data  in  DATA_W  core result.
- src_valid  out  1  result stream valid.
- src_ready  in  1  result stream ready.
- src_data  out  DATA_W  result stream data.
- busy  out  1  high in RUN, DRAIN or FLUSH.
- done  out  1  high in DONE.
- progress  out  CNT_W  results delivered on the source since the last start.

Behaviour:
- Reset (aclr): state IDLE. All outputs 0. FIFO empty. Counters (accepted, inflight, progress, target) cleared.
- FSM states: IDLE, RUN, DRAIN, DONE, FLUSH.
- IDLE / DONE, on ctrl_start:
  - elem_count==0 → DONE.
  - otherwise → RUN; target=elem_count, accepted=0, progress=0.
  - In DONE, a start re-arms the same way.
- RUN:
  - snk_ready = (accepted<target) && (inflight+fifo_level < FIFO_DEPTH). This is a credit scheme; the FIFO can never overflow.
  - Transfer on snk_valid&&snk_ready.
  - core_in_valid/core_in_data are registered: asserted the cycle after the transfer, one cycle wide. Both are 0 when no transfer occurs.
  - inflight increments on issue and decrements on core_out_valid. A simultaneous issue and return leaves inflight unchanged.
  - When accepted reaches target → DRAIN. snk_ready is 0 in the cycle after the last transfer.
- DRAIN: snk_ready=0. When inflight==0, fifo empty and no pending issue → DONE.
- Output path:
  - core_out_valid writes the FIFO.
  - src_valid = FIFO not empty; src_data = FIFO head (show-ahead).
  - Pop on src_valid&&src_ready.
  - progress increments on each pop and saturates at 2^CNT_W-1.
  - A simultaneous push and pop keeps the level unchanged.
- ctrl_start while busy: ignored. target and counters are unchanged.
- ctrl_reset, any state:
  - Takes priority over ctrl_start in the same cycle.
  - FIFO and counters cleared; snk_ready=0; src_valid=0.
  - → FLUSH.
- FLUSH:
  - Wait PIPE_LAT+1 cycles, discarding all core_out_valid, then → IDLE.
  - ctrl_start during FLUSH is ignored.
  - A further ctrl_reset restarts the flush timer.
- Extra DMA beats beyond target are never accepted (snk_ready=0).
- Counter widths: accepted and target use CNT_W. inflight uses clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: FULL_FN_STREAM_EOP_EN.
- Defined:
  - Adds output ports src_startofpacket and src_endofpacket, valid with src_valid.
  - SOP is asserted on the first result after start (progress==0).
  - EOP is asserted on the result for which progress+1==target.
  - For a single-element run, both are asserted on the same beat.
- Undefined: the ports do not exist; all other behaviour is identical.

Test Plan:
- elem_count=4, start, DMA supplies 4 beats back-to-back, src_ready=1 → core_in_valid 4 consecutive cycles, each 1 cycle after its accept. Results appear PIPE_LAT later. progress=4, done=1, busy=0.
- elem_count=0, start → done=1 next cycle; snk_ready never asserts; progress=0.
- elem_count=40, FIFO_DEPTH=32, src_ready=0 → snk_ready drops once inflight+level=32, with exactly 32 accepted. Then src_ready=1 → remaining 8 accepted, progress=40, done.
- elem_count=3, DMA offers 5 beats → only 3 accepted; snk_ready=0 afterward; beats 4–5 stay pending on the sink.
- elem_count=10, ctrl_reset after 5 accepts → FLUSH for PIPE_LAT+1 cycles with src_valid=0 and late core outputs dropped. Then IDLE, progress=0. A new start with count 2 completes with progress=2.
- ctrl_start pulsed mid-RUN with elem_count=99 → ignored; the run completes at the original target. With FULL_FN_STREAM_EOP_EN defined and count=1 → SOP and EOP both high on the single beat.
